// File: rtl/hist_bin_collect_pkg.sv
// Shared definitions for the histogram bin collector: bin/height/word sizes,
// FSM state encoding and small helpers used by the top and its sub-module.
package hist_bin_collect_pkg;

    localparam int unsigned NUM_BINS = 8;
    localparam int unsigned H_W      = 8;
    localparam int unsigned ID_W     = 64;
    localparam int unsigned BIN_W    = 3;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_PACK  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef logic [H_W-1:0] height_t;

    // Width of the normalisation shift amount: s ranges over 0..cnt_w-8.
    function automatic int unsigned shift_w(input int unsigned cnt_w);
        return (cnt_w > 8) ? $clog2(cnt_w - 7) : 1;
    endfunction

    // Pack bar heights into the published word, bin0 in the most significant byte.
    function automatic logic [ID_W-1:0] pack_heights(input height_t h [NUM_BINS]);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NUM_BINS); i++) begin
            r[int'(ID_W) - 1 - i * int'(H_W) -: H_W] = h[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hist_bin_collect_if.sv
// Histogram collector bus: pixel/frame stream into the collector and the
// packed bar-height word out to the draw/colour stage.
//   master : stream source / result consumer
//   slave  : the collector itself
interface hist_bin_collect_if #(
    parameter int unsigned PIX_W = 8
);
    import hist_bin_collect_pkg::*;

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             frame_start;
    logic             frame_end;
    logic [ID_W-1:0]  id_value;
    logic             id_valid;
    logic             busy;

    modport master (
        output pix_data,
        output pix_valid,
        output frame_start,
        output frame_end,
        input  id_value,
        input  id_valid,
        input  busy
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  frame_start,
        input  frame_end,
        output id_value,
        output id_valid,
        output busy
    );

endinterface

// File: rtl/hist_bin_collect_shift_sel.sv
// hist_shift_sel: combinational priority encoder choosing the smallest right
// shift s in 0..CNT_W-8 such that (max_cnt >> s) fits in 8 bits.
//   max_cnt  in  CNT_W  largest bin count of the frame
//   shift_c  out S_W    normalisation shift (0 when max_cnt <= 255)
module hist_shift_sel
    import hist_bin_collect_pkg::*;
#(
    parameter  int unsigned CNT_W = 20,
    localparam int unsigned S_W   = shift_w(CNT_W)
) (
    input  logic [CNT_W-1:0] max_cnt,
    output logic [S_W-1:0]   shift_c
);

    // The highest set bit at position p >= 8 needs s = p - 7; ascending scan,
    // so the last hit (the highest bit) wins.
    always_comb begin
        shift_c = '0;
        for (int i = 1; i <= int'(CNT_W) - 8; i++) begin
            if (max_cnt[i + 7]) begin
                shift_c = S_W'(i);
            end
        end
    end

endmodule

// File: rtl/hist_bin_collect.sv
// hist_bin_collect: bins a luma pixel stream into 8 bins per frame, then at
// frame end normalises the counts to 8-bit bar heights and publishes them as
// one packed word with a single-cycle strobe.
//   clk  in  1     clock, posedge
//   rst  in  1     synchronous active-low reset
//   bus  slave     pix_data/pix_valid/frame_start/frame_end in,
//                  id_value/id_valid/busy out (all outputs registered)
module hist_bin_collect
    import hist_bin_collect_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CNT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    hist_bin_collect_if.slave  bus
);

    localparam int unsigned S_W = shift_w(CNT_W);

    state_t             state;
    logic [CNT_W-1:0]   cnt [NUM_BINS];
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   max_cnt;
    logic [S_W-1:0]     shift;
    height_t            stage [NUM_BINS];
    logic [ID_W-1:0]    id_value_q;
    logic               id_valid_q;
    logic               busy_q;

    logic [BIN_W-1:0]   pix_bin_c;
    logic [CNT_W-1:0]   pix_inc_c;
    logic [CNT_W-1:0]   scan_cnt_c;
    logic [CNT_W-1:0]   shifted_c;
    height_t            height_c;
    logic [S_W-1:0]     shift_c;
    logic               unused_pix_c;

    assign bus.id_value = id_value_q;
    assign bus.id_valid = id_valid_q;
    assign bus.busy     = busy_q;

    // Only the top three luma bits select the bin.
    assign pix_bin_c    = bus.pix_data[PIX_W-1 -: BIN_W];
    assign unused_pix_c = ^bus.pix_data[PIX_W-BIN_W-1:0];

    // Saturating increment of the addressed bin.
    assign pix_inc_c = (cnt[pix_bin_c] == '1) ? cnt[pix_bin_c]
                                              : cnt[pix_bin_c] + CNT_W'(1);

    // Bin under the scan/pack index, and its clipped bar height.
    assign scan_cnt_c = cnt[idx];
    assign shifted_c  = scan_cnt_c >> shift;
    assign height_c   = (|(shifted_c >> H_W)) ? '1 : shifted_c[H_W-1:0];

    hist_shift_sel #(
        .CNT_W   (CNT_W)
    ) u_shift_sel (
        .max_cnt (max_cnt),
        .shift_c (shift_c)
    );

    // Frame FSM, counter bank, staging and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            max_cnt    <= '0;
            shift      <= '0;
            id_value_q <= '0;
            id_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_BINS); i++) begin
                cnt[i]   <= '0;
                stage[i] <= '0;
            end
        end else begin
            id_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        // Clear the bank; a coincident pixel is the frame's first.
                        for (int i = 0; i < int'(NUM_BINS); i++) begin
                            cnt[i] <= '0;
                        end
                        if (bus.pix_valid) begin
                            cnt[pix_bin_c] <= CNT_W'(1);
                        end
                        state <= ST_ACCUM;
                    end
                end

                ST_ACCUM: begin
                    if (bus.frame_end) begin
                        // frame_end beats a coincident frame_start; the last pixel still counts.
                        if (bus.pix_valid) begin
                            cnt[pix_bin_c] <= pix_inc_c;
                        end
                        idx     <= '0;
                        max_cnt <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_SCAN;
                    end else if (bus.frame_start) begin
                        for (int i = 0; i < int'(NUM_BINS); i++) begin
                            cnt[i] <= '0;
                        end
                        if (bus.pix_valid) begin
                            cnt[pix_bin_c] <= CNT_W'(1);
                        end
                    end else if (bus.pix_valid) begin
                        cnt[pix_bin_c] <= pix_inc_c;
                    end
                end

                ST_SCAN: begin
                    if (scan_cnt_c > max_cnt) begin
                        max_cnt <= scan_cnt_c;
                    end
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_BINS - 1)) begin
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    shift <= shift_c;
                    state <= ST_PACK;
                end

                ST_PACK: begin
                    stage[idx] <= height_c;
                    idx        <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_BINS - 1)) begin
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    id_value_q <= pack_heights(stage);
                    id_valid_q <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hist_bin_collect.sv
// Bench for hist_bin_collect: two instances (CNT_W=20 and CNT_W=9) share one
// stimulus stream; results are compared with hand-computed table values and a
// count/normalise reference model.
module tb_hist_bin_collect;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hist_bin_collect_if #(.PIX_W(8)) bus20 ();
    hist_bin_collect_if #(.PIX_W(8)) bus9 ();

    hist_bin_collect #(.PIX_W(8), .CNT_W(20)) dut20 (
        .clk (clk),
        .rst (rst),
        .bus (bus20.slave)
    );

    hist_bin_collect #(.PIX_W(8), .CNT_W(9)) dut9 (
        .clk (clk),
        .rst (rst),
        .bus (bus9.slave)
    );

    typedef struct {
        logic [7:0][10:0] n;
        logic [63:0]      e20;
        logic [63:0]      e9;
    } vec_t;

    vec_t vt [7];

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Reference: count per bin with saturation, pick smallest shift fitting the max in 8 bits.
    function automatic logic [63:0] model(input logic [7:0][10:0] n, input int unsigned cw);
        longint unsigned top, c, mx;
        int s;
        logic [63:0] r;
        top = (64'd1 << cw) - 64'd1;
        mx = 0;
        s = 0;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            c = (64'(n[b]) > top) ? top : 64'(n[b]);
            if (c > mx) mx = c;
        end
        while ((mx >> s) > 255) s++;
        for (int b = 0; b < 8; b++) begin
            c = (64'(n[b]) > top) ? top : 64'(n[b]);
            c = c >> s;
            if (c > 255) c = 255;
            r[63 - 8 * b -: 8] = 8'(c);
        end
        return r;
    endfunction

    task automatic drive(input bit fs, input bit fe, input bit pv, input logic [7:0] pd);
        bus20.frame_start = fs;
        bus20.frame_end   = fe;
        bus20.pix_valid   = pv;
        bus20.pix_data    = pd;
        bus9.frame_start  = fs;
        bus9.frame_end    = fe;
        bus9.pix_valid    = pv;
        bus9.pix_data     = pd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        chk({name, " id_value20"}, bus20.id_value, 64'd0);
        chk({name, " id_value9"},  bus9.id_value,  64'd0);
        chk({name, " id_valid"},   64'({bus20.id_valid, bus9.id_valid}), 64'd0);
        chk({name, " busy"},       64'({bus20.busy, bus9.busy}), 64'd0);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (bus20.id_valid || bus9.id_valid) n++;
        end
        chk({name, " strobes"}, 64'(n), 64'd0);
    endtask

    // Frame: frame_start alone, shuffled pixels (optional idle gaps), then frame_end.
    task automatic emit_frame(input logic [7:0][10:0] n, input bit end_pix, input bit gaps);
        int unsigned q[$];
        int unsigned t;
        int j;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < int'(n[b]); k++) q.push_back(b);
        end
        for (int i = q.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = q[i];
            q[i] = q[j];
            q[j] = t;
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(3, 0) == 0) begin
                drive(1'b0, 1'b0, 1'b0, 8'($urandom));
                step();
            end
            drive(1'b0, end_pix && (i == q.size() - 1), 1'b1, {3'(q[i]), 5'($urandom)});
            step();
        end
        if (!(end_pix && q.size() > 0)) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Called just after the edge that sampled frame_end; strobe is due 18 edges later.
    task automatic wait_result(input logic [63:0] e20, input logic [63:0] e9, input string name,
                               input bit disturb, input bit chain);
        int lat20, lat9;
        logic [63:0] v20, v9;
        bit busy_ok;
        lat20 = -1;
        lat9 = -1;
        v20 = '0;
        v9 = '0;
        busy_ok = bus20.busy && bus9.busy;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus20.id_valid && lat20 < 0) begin
                lat20 = k;
                v20 = bus20.id_value;
            end
            if (bus9.id_valid && lat9 < 0) begin
                lat9 = k;
                v9 = bus9.id_value;
            end
            if (k <= 16) busy_ok = busy_ok && bus20.busy && bus9.busy;
            else if (k == 17) busy_ok = busy_ok && !bus20.busy && !bus9.busy;
            if (disturb) begin
                if (k >= 10 && k <= 16) drive(k == 10, k == 16, 1'b1, 8'($urandom));
                else if (k == 17) drive(1'b1, 1'b0, 1'b1, 8'($urandom));
                else drive(1'b0, 1'b0, 1'b0, 8'h00);
            end
            if (lat20 >= 0 && lat9 >= 0) break;
        end
        chk({name, " latency20"}, 64'(lat20), 64'd18);
        chk({name, " latency9"},  64'(lat9),  64'd18);
        chk({name, " value20"},   v20, e20);
        chk({name, " value9"},    v9,  e9);
        chk({name, " busy"},      64'(busy_ok), 64'd1);
        if (!chain) begin
            step();
            chk({name, " strobe_width"}, 64'({bus20.id_valid, bus9.id_valid}), 64'd0);
            chk({name, " hold20"}, bus20.id_value, e20);
        end
    endtask

    initial begin
        logic [7:0][10:0] rn;

        for (int i = 0; i < 7; i++) vt[i].n = '0;
        vt[0].n[0] = 11'd10;   vt[0].n[7] = 11'd5;
        vt[0].e20 = 64'h0A00_0000_0000_0005;  vt[0].e9 = 64'h0A00_0000_0000_0005;
        vt[1].n[3] = 11'd1000; vt[1].n[5] = 11'd250;
        vt[1].e20 = 64'h0000_00FA_003E_0000;  vt[1].e9 = 64'h0000_00FF_007D_0000;
        vt[2].n[0] = 11'd600;
        vt[2].e20 = 64'h9600_0000_0000_0000;  vt[2].e9 = 64'hFF00_0000_0000_0000;
        vt[3].e20 = 64'h0;                    vt[3].e9 = 64'h0;
        for (int b = 0; b < 8; b++) vt[4].n[b] = 11'd300;
        vt[4].e20 = 64'h9696_9696_9696_9696;  vt[4].e9 = 64'h9696_9696_9696_9696;
        vt[5].n[6] = 11'd255;  vt[5].n[2] = 11'd1;
        vt[5].e20 = 64'h0000_0100_0000_FF00;  vt[5].e9 = 64'h0000_0100_0000_FF00;
        vt[6].n[4] = 11'd256;
        vt[6].e20 = 64'h0000_0000_8000_0000;  vt[6].e9 = 64'h0000_0000_8000_0000;

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) step();
        check_reset("por");
        rst = 1'b1;
        step();
        check_reset("por_release");

        // Table frames.
        for (int i = 0; i < 7; i++) begin
            emit_frame(vt[i].n, 1'(i % 2), 1'b1);
            wait_result(vt[i].e20, vt[i].e9, $sformatf("vec%0d", i), 1'b0, 1'b0);
        end

        // Reset held 3 cycles in the middle of accumulation.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b1, 8'($urandom));
            step();
        end
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        check_reset("rst_accum");
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        watch_quiet("rst_accum", 30);

        // Reset during PACK: no partial result.
        emit_frame(vt[4].n, 1'b0, 1'b0);
        repeat (12) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_reset("rst_pack");
        watch_quiet("rst_pack", 30);

        // Pixels coinciding with frame_start and frame_end both count.
        drive(1'b1, 1'b0, 1'b1, 8'h20);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) step();
        drive(1'b0, 1'b1, 1'b1, 8'h3F);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        wait_result(64'h0002_0000_0000_0000, 64'h0002_0000_0000_0000, "edge", 1'b0, 1'b0);

        // frame_start with frame_end in ACCUM: end wins, counts kept.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b1, 8'h40);
            step();
        end
        drive(1'b1, 1'b1, 1'b1, 8'h45);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        wait_result(64'h0000_0400_0000_0000, 64'h0000_0400_0000_0000, "start_end", 1'b0, 1'b0);

        // frame_start mid-ACCUM restarts the frame.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        repeat (5) begin
            drive(1'b0, 1'b0, 1'b1, 8'hC3);
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 8'hE0);
        step();
        drive(1'b0, 1'b0, 1'b1, 8'hFF);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        wait_result(64'h0000_0000_0000_0002, 64'h0000_0000_0000_0002, "restart", 1'b0, 1'b0);

        // Frame traffic while busy/DONE is dropped; frame_end in IDLE ignored.
        emit_frame(vt[0].n, 1'b0, 1'b0);
        wait_result(vt[0].e20, vt[0].e9, "busy_drop", 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        watch_quiet("idle_end", 25);
        emit_frame(vt[5].n, 1'b1, 1'b1);
        wait_result(vt[5].e20, vt[5].e9, "after_drop", 1'b0, 1'b0);

        // Random frames, back to back (frame_start in the cycle after DONE).
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < 8; b++) begin
                rn[b] = 11'($urandom_range((f == 0) ? 600 : 60, 0));
                if ($urandom_range(3, 0) == 0) rn[b] = '0;
            end
            emit_frame(rn, 1'($urandom_range(1, 0)), 1'b1);
            wait_result(model(rn, 20), model(rn, 9), $sformatf("rand%0d", f), 1'b0, 1'(f == 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
